memory_responder: RTL and testbench

- Target-side memory port serving the multicycle core's unified instruction/data accesses.
- Adds a configurable wait-state handshake, so the core must hold a request until the responder answers, instead of getting zero-latency combinational reads.
- Maps byte addresses in the text and data segments onto two internal word arrays.
- Flags misaligned, unmapped and conflicting accesses.

---
 rtl/memory_responder.sv | 164 ++++++++++++++++
 tb/tb_memory_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Wait-state memory responder: maps text/data byte addresses onto two word arrays
// and answers each accepted request with a one-cycle oReady pulse, qualified by oError.
module memory_responder #(
    parameter logic [31:0] TEXT_BASE   = 32'h0040_0000,
    parameter logic [31:0] DATA_BASE   = 32'h1001_0000,
    parameter int unsigned TEXT_WORDS  = 1024,
    parameter int unsigned DATA_WORDS  = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] iAddress,
    input  logic [31:0] iData,
    input  logic        read,
    input  logic        write,
    output logic [31:0] oData,
    output logic [31:0] oAddress,
    output logic        oReady,
    output logic        oBusy,
    output logic        oError
);

    localparam int unsigned TW = $clog2(TEXT_WORDS);
    localparam int unsigned DW = $clog2(DATA_WORDS);

    localparam logic [32:0] TEXT_LO = {1'b0, TEXT_BASE};
    localparam logic [32:0] TEXT_HI = TEXT_LO + 33'(TEXT_WORDS) * 33'd4;
    localparam logic [32:0] DATA_LO = {1'b0, DATA_BASE};
    localparam logic [32:0] DATA_HI = DATA_LO + 33'(DATA_WORDS) * 33'd4;

    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] oaddr_q, oaddr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic        dseg_q, dseg_d;

    logic [31:0] text_mem [TEXT_WORDS];
    logic [31:0] data_mem [DATA_WORDS];

    logic [32:0] addr33;
    logic        text_hit, data_hit;
    logic [29:0] text_idx, data_idx;
    logic [TW-1:0] tidx;
    logic [DW-1:0] didx;

    // Word-granular offsets; the bases are word aligned so the low two bits never matter.
    always_comb begin
        addr33   = {1'b0, iAddress};
        text_hit = (addr33 >= TEXT_LO) && (addr33 < TEXT_HI);
        data_hit = (addr33 >= DATA_LO) && (addr33 < DATA_HI);
        text_idx = iAddress[31:2] - TEXT_BASE[31:2];
        data_idx = iAddress[31:2] - DATA_BASE[31:2];
    end

    assign tidx = oaddr_q[TW-1:0];
    assign didx = oaddr_q[DW-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        oaddr_d = oaddr_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        dseg_d  = dseg_q;

        case (state_q)
            S_IDLE: begin
                if (read || write) begin
                    wdata_d = iData;
                    wr_d    = write;
                    err_d   = (iAddress[1:0] != 2'b00) || !(text_hit || data_hit) || (read && write);
                    dseg_d  = !text_hit && data_hit;
                    if (text_hit) begin
                        oaddr_d = {2'b00, text_idx};
                    end else if (data_hit) begin
                        oaddr_d = {2'b10, data_idx};
                    end else begin
                        oaddr_d = '0;
                    end
                    cnt_d   = '0;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                // Withdrawing the request aborts it; abort wins over the move to ACCESS.
                if (!read && !write) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACCESS: begin
                if (!err_q && !wr_q) begin
                    rdata_d = dseg_q ? data_mem[didx] : text_mem[tidx];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wdata_q <= '0;
            oaddr_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            dseg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            oaddr_q <= oaddr_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            dseg_q  <= dseg_d;
        end
    end

    // Reset forces state_q to IDLE asynchronously, so no commit can happen under reset.
    always_ff @(posedge clock) begin
        if (state_q == S_ACCESS && wr_q && !err_q) begin
            if (dseg_q) begin
                data_mem[didx] <= wdata_q;
            end else begin
                text_mem[tidx] <= wdata_q;
            end
        end
    end

    assign oData    = rdata_q;
    assign oAddress = oaddr_q;
    assign oReady   = (state_q == S_DONE);
    assign oBusy    = (state_q != S_IDLE);
    assign oError   = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: directed scenarios plus randomized traffic
// compared against an address-rule model with associative-array memories.
module tb_memory_responder;

    localparam logic [31:0] TB = 32'h0040_0000;
    localparam logic [31:0] DB = 32'h1001_0000;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] iAddress = '0, iData = '0, oData, oAddress;
    logic        read = 1'b0, write = 1'b0, oReady, oBusy, oError;
    logic [31:0] iAddress0 = '0, iData0 = '0, oData0, oAddress0;
    logic        read0 = 1'b0, write0 = 1'b0, oReady0, oBusy0, oError0;

    memory_responder #(.WAIT_STATES(2)) dut (
        .clock(clock), .resetn(resetn), .iAddress(iAddress), .iData(iData),
        .read(read), .write(write), .oData(oData), .oAddress(oAddress),
        .oReady(oReady), .oBusy(oBusy), .oError(oError)
    );

    memory_responder #(.WAIT_STATES(0)) dut0 (
        .clock(clock), .resetn(resetn), .iAddress(iAddress0), .iData(iData0),
        .read(read0), .write(write0), .oData(oData0), .oAddress(oAddress0),
        .oReady(oReady0), .oBusy(oBusy0), .oError(oError0)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] tm [int];
    logic [31:0] dm [int];
    logic [31:0] m_rdata = '0;

    // Reference decode straight from the address rules, in wide arithmetic.
    function automatic void ref_decode(input logic [31:0] a, input logic r, input logic w,
                                       output logic err, output logic mapped,
                                       output logic [31:0] oadr, output bit is_data,
                                       output int idx);
        longint la, lt, ld;
        bit in_t, in_d;
        la = longint'(a);
        lt = longint'(TB);
        ld = longint'(DB);
        in_t = (la >= lt) && (la < lt + 4 * 1024);
        in_d = (la >= ld) && (la < ld + 4 * 1024);
        mapped  = in_t || in_d;
        is_data = !in_t && in_d;
        idx     = in_t ? int'((la - lt) / 4) : int'((la - ld) / 4);
        oadr    = is_data ? (32'h8000_0000 | 32'(idx)) : 32'(idx);
        err     = (a % 4 != 0) || !mapped || (r && w);
    endfunction

    // One complete transaction; lat counts edges with the accepting edge as 1, -1 on timeout.
    task automatic txn(input bit sel, input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic w, output int lat,
                       output logic [31:0] rdat, output logic [31:0] oadr,
                       output logic err, output logic busy1, output logic after);
        lat = -1; rdat = '0; oadr = '0; err = 1'b0; busy1 = 1'b0; after = 1'b1;
        if (!sel) begin
            iAddress = a; iData = d; read = r; write = w;
        end else begin
            iAddress0 = a; iData0 = d; read0 = r; write0 = w;
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock); #1;
            if (n == 1) busy1 = sel ? oBusy0 : oBusy;
            if (sel ? oReady0 : oReady) begin
                lat  = n;
                rdat = sel ? oData0 : oData;
                oadr = sel ? oAddress0 : oAddress;
                err  = sel ? oError0 : oError;
                break;
            end
        end
        read = 1'b0; write = 1'b0; read0 = 1'b0; write0 = 1'b0;
        @(posedge clock); #1;
        after = sel ? (oReady0 | oBusy0 | oError0) : (oReady | oBusy | oError);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({oData, oAddress, oReady, oBusy, oError} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h/%b%b%b required all zero", oData, oAddress, oReady, oBusy, oError);
        end
        checks++;
        if ({oData0, oAddress0, oReady0, oBusy0, oError0} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs_ws0: got %h/%h/%b%b%b required all zero", oData0, oAddress0, oReady0, oBusy0, oError0);
        end
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checks++;
            if ({oData, oAddress, oReady, oBusy, oError} !== 67'd0) begin
                errors++;
                $display("FAIL idle_outputs cycle %0d: got %h/%h/%b%b%b required all zero", i, oData, oAddress, oReady, oBusy, oError);
            end
        end
        m_rdata = '0;
    endtask

    task automatic test_text_read_latency();
        int lat; logic [31:0] rd, oa; logic er, b1, af;
        txn(0, TB, 32'h0050_0093, 1'b0, 1'b1, lat, rd, oa, er, b1, af);
        tm[0] = 32'h0050_0093;
        checks++;
        if (lat !== 4 || er !== 1'b0) begin
            errors++;
            $display("FAIL text_preload: lat %0d err %b required lat 4 err 0", lat, er);
        end
        txn(0, TB, 32'h0, 1'b1, 1'b0, lat, rd, oa, er, b1, af);
        m_rdata = 32'h0050_0093;
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL text_read_latency: got %0d required 4", lat); end
        checks++;
        if (rd !== 32'h0050_0093) begin errors++; $display("FAIL text_read_data: got %h required 00500093", rd); end
        checks++;
        if (oa !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL text_read_addr_err: got %h/%b required 00000000/0", oa, er); end
        checks++;
        if (b1 !== 1'b1) begin errors++; $display("FAIL busy_on_accept: got %b required 1", b1); end
        checks++;
        if (af !== 1'b0) begin errors++; $display("FAIL ready_one_cycle: after-pulse flags %b required 0", af); end
    endtask

    task automatic test_data_rw();
        int lat; logic [31:0] rd, oa; logic er, b1, af;
        txn(0, DB + 32'h8, 32'hDEAD_BEEF, 1'b0, 1'b1, lat, rd, oa, er, b1, af);
        dm[2] = 32'hDEAD_BEEF;
        checks++;
        if (er !== 1'b0 || oa !== 32'h8000_0002) begin errors++; $display("FAIL data_write: err %b oaddr %h required 0/80000002", er, oa); end
        checks++;
        if (rd !== m_rdata) begin errors++; $display("FAIL write_keeps_odata: got %h required %h", rd, m_rdata); end
        txn(0, DB + 32'h8, 32'h0, 1'b1, 1'b0, lat, rd, oa, er, b1, af);
        m_rdata = 32'hDEAD_BEEF;
        checks++;
        if (rd !== 32'hDEAD_BEEF || oa !== 32'h8000_0002 || er !== 1'b0) begin
            errors++;
            $display("FAIL data_readback: got %h/%h/%b required deadbeef/80000002/0", rd, oa, er);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd, oa; logic er, b1, af;
        txn(0, DB + 32'h2, 32'h0, 1'b1, 1'b0, lat, rd, oa, er, b1, af);
        checks++;
        if (er !== 1'b1 || lat !== 4 || rd !== m_rdata) begin
            errors++;
            $display("FAIL misaligned_read: err %b lat %0d data %h required 1/4/%h", er, lat, rd, m_rdata);
        end
        txn(0, 32'h0, 32'h0, 1'b1, 1'b0, lat, rd, oa, er, b1, af);
        checks++;
        if (er !== 1'b1 || rd !== m_rdata) begin errors++; $display("FAIL unmapped_read: err %b data %h required 1/%h", er, rd, m_rdata); end
        txn(0, DB, 32'h1122_3344, 1'b0, 1'b1, lat, rd, oa, er, b1, af);
        dm[0] = 32'h1122_3344;
        txn(0, DB, 32'h0BAD_0BAD, 1'b1, 1'b1, lat, rd, oa, er, b1, af);
        checks++;
        if (er !== 1'b1 || lat !== 4) begin errors++; $display("FAIL both_ops: err %b lat %0d required 1/4", er, lat); end
        txn(0, DB, 32'h0, 1'b1, 1'b0, lat, rd, oa, er, b1, af);
        m_rdata = dm[0];
        checks++;
        if (rd !== 32'h1122_3344 || er !== 1'b0) begin errors++; $display("FAIL both_ops_no_write: got %h/%b required 11223344/0", rd, er); end
    endtask

    task automatic test_boundaries();
        int lat; logic [31:0] rd, oa; logic er, b1, af;
        txn(0, TB + 32'hFFC, 32'hCAFE_F00D, 1'b0, 1'b1, lat, rd, oa, er, b1, af);
        tm[1023] = 32'hCAFE_F00D;
        txn(0, TB + 32'hFFC, 32'h0, 1'b1, 1'b0, lat, rd, oa, er, b1, af);
        m_rdata = tm[1023];
        checks++;
        if (er !== 1'b0 || rd !== 32'hCAFE_F00D || oa !== 32'h3FF) begin
            errors++;
            $display("FAIL text_last_word: got %b/%h/%h required 0/cafef00d/000003ff", er, rd, oa);
        end
        txn(0, TB + 32'h1000, 32'h0, 1'b1, 1'b0, lat, rd, oa, er, b1, af);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL text_past_end: err %b required 1", er); end
        txn(0, TB - 32'h4, 32'h0, 1'b1, 1'b0, lat, rd, oa, er, b1, af);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL text_below_base: err %b required 1", er); end
        txn(0, DB + 32'hFFC, 32'h1357_9BDF, 1'b0, 1'b1, lat, rd, oa, er, b1, af);
        dm[1023] = 32'h1357_9BDF;
        txn(0, DB + 32'hFFC, 32'h0, 1'b1, 1'b0, lat, rd, oa, er, b1, af);
        m_rdata = dm[1023];
        checks++;
        if (er !== 1'b0 || rd !== 32'h1357_9BDF || oa !== 32'h8000_03FF) begin
            errors++;
            $display("FAIL data_last_word: got %b/%h/%h required 0/13579bdf/800003ff", er, rd, oa);
        end
        txn(0, DB + 32'h1000, 32'h0, 1'b1, 1'b0, lat, rd, oa, er, b1, af);
        checks++;
        if (er !== 1'b1 || rd !== m_rdata) begin errors++; $display("FAIL data_past_end: err %b data %h required 1/%h", er, rd, m_rdata); end
    endtask

    task automatic test_ws0();
        int lat; logic [31:0] rd, oa; logic er, b1, af;
        txn(1, TB + 32'h4, 32'hA5A5_0001, 1'b0, 1'b1, lat, rd, oa, er, b1, af);
        checks++;
        if (lat !== 2 || er !== 1'b0) begin errors++; $display("FAIL ws0_write_latency: lat %0d err %b required 2/0", lat, er); end
        txn(1, TB + 32'h4, 32'h0, 1'b1, 1'b0, lat, rd, oa, er, b1, af);
        checks++;
        if (lat !== 2 || rd !== 32'hA5A5_0001 || oa !== 32'h1) begin
            errors++;
            $display("FAIL ws0_read: lat %0d data %h oaddr %h required 2/a5a50001/00000001", lat, rd, oa);
        end
        checks++;
        if (af !== 1'b0) begin errors++; $display("FAIL ws0_ready_one_cycle: flags %b required 0", af); end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1;
        iAddress = DB + 32'h8; read = 1'b1;
        for (int n = 1; n <= 40 && second < 0; n++) begin
            @(posedge clock); #1;
            if (oReady) begin
                if (first < 0) first = n; else second = n;
            end
        end
        read = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        m_rdata = dm[2];
        checks++;
        if (first !== 4 || second !== 9) begin
            errors++;
            $display("FAIL held_request_reaccepted: pulses at %0d,%0d required 4,9", first, second);
        end
        checks++;
        if (oData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL held_request_data: got %h required deadbeef", oData); end
    endtask

    task automatic test_abort();
        int lat; logic [31:0] rd, oa; logic er, b1, af;
        logic saw = 1'b0;
        iAddress = DB + 32'h8; iData = 32'h5555_5555; write = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (oBusy !== 1'b1) begin errors++; $display("FAIL abort_busy_in_wait: got %b required 1", oBusy); end
        write = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (oBusy !== 1'b0 || oReady !== 1'b0) begin errors++; $display("FAIL abort_to_idle: busy %b ready %b required 0/0", oBusy, oReady); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            saw = saw | oReady | oBusy;
        end
        checks++;
        if (saw !== 1'b0) begin errors++; $display("FAIL abort_no_ready: activity %b required 0", saw); end
        txn(0, DB + 32'h8, 32'h0, 1'b1, 1'b0, lat, rd, oa, er, b1, af);
        m_rdata = dm[2];
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL abort_no_write: got %h required deadbeef", rd); end
    endtask

    task automatic test_random();
        int lat, idx, kind; logic [31:0] rd, oa, a, d, e_oa, e_rd; logic er, b1, af, r, w, e_err, mapped;
        bit is_d, seg;
        for (int k = 0; k < 60; k++) begin
            kind = int'($urandom_range(0, 5));
            seg  = 1'($urandom_range(0, 1));
            a    = (seg ? DB : TB) + 32'($urandom_range(0, 15)) * 32'd4;
            d    = $urandom;
            r = 1'b0; w = 1'b0;
            case (kind)
                0, 1: w = 1'b1;
                2, 3: r = 1'b1;
                4: begin a = a + 32'($urandom_range(1, 3)); r = 1'($urandom_range(0, 1)); w = !r; end
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        a = 32'h2000_0000 + 32'($urandom_range(0, 255)) * 32'd4; r = 1'b1;
                    end else begin
                        r = 1'b1; w = 1'b1;
                    end
                end
            endcase
            ref_decode(a, r, w, e_err, mapped, e_oa, is_d, idx);
            if (!e_err && r && !(is_d ? dm.exists(idx) : tm.exists(idx))) begin
                r = 1'b0; w = 1'b1;
            end
            if (!e_err) begin
                if (w) begin
                    if (is_d) dm[idx] = d; else tm[idx] = d;
                end else begin
                    m_rdata = is_d ? dm[idx] : tm[idx];
                end
            end
            e_rd = m_rdata;
            txn(0, a, d, r, w, lat, rd, oa, er, b1, af);
            checks++;
            if (lat !== 4 || er !== e_err || rd !== e_rd || (mapped && oa !== e_oa)) begin
                errors++;
                $display("FAIL random[%0d] a=%h r%b w%b: lat %0d err %b data %h oaddr %h required 4/%b/%h/%h",
                         k, a, r, w, lat, er, rd, oa, e_err, e_rd, e_oa);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd, oa; logic er, b1, af;
        iAddress = DB + 32'h8; iData = 32'h7777_7777; write = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (oBusy !== 1'b1 || oReady !== 1'b0) begin errors++; $display("FAIL reset_mid_in_access: busy %b ready %b required 1/0", oBusy, oReady); end
        resetn = 1'b0;
        #1;
        checks++;
        if ({oData, oAddress, oReady, oBusy, oError} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h/%h/%b%b%b required all zero", oData, oAddress, oReady, oBusy, oError);
        end
        write = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        m_rdata = '0;
        @(posedge clock); #1;
        txn(0, DB + 32'h8, 32'h0, 1'b1, 1'b0, lat, rd, oa, er, b1, af);
        checks++;
        if (rd !== dm[2] || er !== 1'b0) begin errors++; $display("FAIL reset_mid_no_write: got %h/%b required %h/0", rd, er, dm[2]); end
    endtask

    initial begin
        test_reset();
        test_text_read_latency();
        test_data_rw();
        test_errors();
        test_boundaries();
        test_ws0();
        test_back_to_back();
        test_abort();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
